conv_window_addr_gen: RTL and testbench

CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

---
 rtl/conv_window_addr_gen.sv | 119 +++++++++++
 tb/tb_conv_window_addr_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_addr_gen.sv
// rtl/conv_window_addr_gen.sv - sliding KxK window read-address generator
// Stride-1, no-padding scan of an IMG_W x IMG_H feature map with a valid/ready address port.
module conv_window_addr_gen #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 3,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic                 win_last,
  output logic                 frame_done
);

  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   row, col, kr, kc;
  logic [CW-1:0]   n_row, n_col, n_kr, n_kc;
  logic            kc_wrap, kr_wrap, col_wrap, row_end, frame_last, xfer;
  logic            n_win_last;
  logic [ADDR_BITS-1:0] n_addr;

  // Next position in kc -> kr -> col -> row order, and its address.
  always_comb begin
    xfer       = addr_valid & addr_ready;
    kc_wrap    = (kc  == CW'(K - 1));
    kr_wrap    = (kr  == CW'(K - 1));
    col_wrap   = (col == CW'(IMG_W - K));
    row_end    = (row == CW'(IMG_H - K));
    frame_last = kc_wrap & kr_wrap & col_wrap & row_end;

    n_kc  = kc_wrap ? '0 : kc + CW'(1);
    n_kr  = kr;
    n_col = col;
    n_row = row;
    if (kc_wrap) begin
      n_kr = kr_wrap ? '0 : kr + CW'(1);
      if (kr_wrap) begin
        n_col = col_wrap ? '0 : col + CW'(1);
        if (col_wrap) begin
          n_row = row + CW'(1);
        end
      end
    end

    n_addr     = ADDR_BITS'(32'(n_row + n_kr) * 32'(IMG_W) + 32'(n_col + n_kc));
    n_win_last = (n_kc == CW'(K - 1)) && (n_kr == CW'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      kr         <= '0;
      kc         <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      win_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            state      <= RUN;
            row        <= '0;
            col        <= '0;
            kr         <= '0;
            kc         <= '0;
            addr       <= '0;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
            win_last   <= (K == 1);
          end
        end
        RUN: begin
          if (xfer) begin
            if (frame_last) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              busy       <= 1'b0;
              win_last   <= 1'b0;
              frame_done <= 1'b1;
              row        <= '0;
              col        <= '0;
              kr         <= '0;
              kc         <= '0;
            end else begin
              row      <= n_row;
              col      <= n_col;
              kr       <= n_kr;
              kc       <= n_kc;
              addr     <= n_addr;
              win_last <= n_win_last;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// tb/tb_conv_window_addr_gen.sv - bench for conv_window_addr_gen
// Small (4,4,2,4) and default-parameter instances checked against a nested-loop address model.
module tb_conv_window_addr_gen;

  logic clk = 1'b0;
  logic rst, start, addr_ready, sel;

  always #5 clk = ~clk;

  logic       busy_s, av_s, wl_s, fd_s;
  logic [3:0] addr_s;
  logic       busy_d, av_d, wl_d, fd_d;
  logic [9:0] addr_d;

  conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .K(2), .ADDR_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start & ~sel),
    .busy       (busy_s),
    .addr       (addr_s),
    .addr_valid (av_s),
    .addr_ready (addr_ready & ~sel),
    .win_last   (wl_s),
    .frame_done (fd_s)
  );

  conv_window_addr_gen dut_d (
    .clk        (clk),
    .rst        (rst),
    .start      (start & sel),
    .busy       (busy_d),
    .addr       (addr_d),
    .addr_valid (av_d),
    .addr_ready (addr_ready & sel),
    .win_last   (wl_d),
    .frame_done (fd_d)
  );

  logic [31:0] cur_busy, cur_valid, cur_wl, cur_fd, cur_addr;
  assign cur_busy  = 32'(sel ? busy_d : busy_s);
  assign cur_valid = 32'(sel ? av_d   : av_s);
  assign cur_wl    = 32'(sel ? wl_d   : wl_s);
  assign cur_fd    = 32'(sel ? fd_d   : fd_s);
  assign cur_addr  = sel ? 32'(addr_d) : 32'(addr_s);

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int kk;
  int n;
  int last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference order: every output position, and within it every kernel tap row-major.
  function automatic void build(input int w, input int h, input int k);
    exp_q.delete();
    kk = k * k;
    for (int r = 0; r <= h - k; r++)
      for (int c = 0; c <= w - k; c++)
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            exp_q.push_back((r + i) * w + (c + j));
  endfunction

  task automatic scan(input int pct, input bit poke, output int cnt);
    int  cyc;
    bit  stalled;
    logic [31:0] prev;
    cnt = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    @(negedge clk);
    start = 1'b1;
    addr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", cur_busy, 1);
    while (cnt < exp_q.size() && cyc < 30000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (stalled) chk("stall_hold", cur_addr, prev);
      chk("valid_in_run", cur_valid, 1);
      chk("no_early_done", cur_fd, 0);
      addr_ready = ($urandom_range(0, 99) < pct);
      start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (addr_ready) begin
        chk("addr", cur_addr, exp_q[cnt]);
        chk("win_last", cur_wl, 32'((cnt % kk) == kk - 1));
        last_addr = int'(cur_addr);
        cnt++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = cur_addr;
      end
    end
    if (cyc >= 30000) chk("scan_timeout", 0, 1);
    @(negedge clk);
    addr_ready = 1'b0;
    start = poke;
    chk("frame_done", cur_fd, 1);
    chk("busy_in_done", cur_busy, 0);
    chk("valid_in_done", cur_valid, 0);
    @(negedge clk);
    start = 1'b0;
    chk("frame_done_pulse", cur_fd, 0);
    chk("idle_after_done", cur_busy, 0);
  endtask

  initial begin
    int cyc;
    sel = 1'b0;
    start = 1'b0;
    addr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy",  cur_busy,  0);
      chk("rst_valid", cur_valid, 0);
      chk("rst_addr",  cur_addr,  0);
      chk("rst_wl",    cur_wl,    0);
      chk("rst_fd",    cur_fd,    0);
    end
    sel = 1'b0;
    rst = 1'b0;

    build(4, 4, 2);
    scan(100, 1'b0, n);
    chk("count_full_rate", n, 36);
    chk("final_addr_small", last_addr, 15);
    scan(50, 1'b0, n);
    chk("count_random_ready", n, 36);
    scan(65, 1'b1, n);
    chk("count_start_pokes", n, 36);

    // Reset after seven transfers abandons the frame.
    @(negedge clk);
    start = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("pre_rst_addr", cur_addr, exp_q[i]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr_ready = 1'b0;
    chk("midrst_busy",  cur_busy,  0);
    chk("midrst_valid", cur_valid, 0);
    chk("midrst_addr",  cur_addr,  0);
    chk("midrst_fd",    cur_fd,    0);
    @(negedge clk);
    chk("midrst_no_fd", cur_fd, 0);
    scan(80, 1'b0, n);
    chk("count_after_rst", n, 36);

    // Start held high: one IDLE cycle between frames.
    @(negedge clk);
    start = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    n = 0;
    cyc = 0;
    while (cur_fd !== 32'd1 && cyc < 200) begin
      if (cur_valid === 32'd1 && n < exp_q.size()) begin
        chk("held_addr", cur_addr, exp_q[n]);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("held_count", n, 36);
    chk("held_fd", cur_fd, 1);
    @(negedge clk);
    chk("held_idle_busy", cur_busy, 0);
    chk("held_idle_fd", cur_fd, 0);
    @(negedge clk);
    start = 1'b0;
    chk("held_restart_busy", cur_busy, 1);
    chk("held_restart_valid", cur_valid, 1);
    chk("held_restart_addr", cur_addr, 0);
    cyc = 0;
    while (cur_fd !== 32'd1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_drain_fd", cur_fd, 1);
    @(negedge clk);
    addr_ready = 1'b0;

    sel = 1'b1;
    build(28, 28, 3);
    scan(100, 1'b0, n);
    chk("count_default", n, 6084);
    chk("final_addr_default", last_addr, 783);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
